// File: rtl/alu_mismatch_monitor.sv
// alu_mismatch_monitor
// Watches the dual-ALU lockstep compare flags, counts samples and mismatches,
// captures the first failing result pair and raises a level interrupt once the
// mismatch count reaches a programmable threshold. Wishbone slave for control.
module alu_mismatch_monitor #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          CNT_W      = 16,
    parameter int unsigned DEF_THRESH = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  alu_out1,
    input  logic [3:0]  alu_out2,
    input  logic        carry1,
    input  logic        carry2,
    input  logic [3:0]  x,
    input  logic        y,
    input  logic        sample_en,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq
);

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_SAMPLE = 8'h08;
    localparam logic [7:0] OFF_MISM   = 8'h0C;
    localparam logic [7:0] OFF_CAPT   = 8'h10;
    localparam logic [7:0] OFF_THRESH = 8'h14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             irq_q, irq_d;
    logic             running_s, fault_s;
    logic             ack_q;
    logic [31:0]      dat_q;
    logic             en_q;
    logic [CNT_W-1:0] thresh_q;
    logic [31:0]      sample_cnt_q;
    logic [CNT_W-1:0] mism_cnt_q;
    logic [31:0]      capture_q;
    logic             cap_q;

    logic             hit_s, req_s, wr_s;
    logic [7:0]       offset_s;
    logic             ctrl_wr_s, clr_s, en_off_s, thresh_wr_s;
    logic             samp_s, mism_s;
    logic [31:0]      cap_word_s;
    logic [31:0]      thresh_ext_s, mism_ext_s, thresh_wdat_s, rdata_s;
    logic             unused_s;

    // Bus decode: a new access is accepted only when no ack is currently out.
    assign hit_s       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign offset_s    = wbs_adr_i[7:0];
    assign req_s       = wbs_stb_i & wbs_cyc_i & hit_s & ~ack_q;
    assign wr_s        = req_s & wbs_we_i;
    assign ctrl_wr_s   = wr_s & (offset_s == OFF_CTRL) & wbs_sel_i[0];
    assign clr_s       = ctrl_wr_s & wbs_dat_i[1];
    assign en_off_s    = ctrl_wr_s & ~wbs_dat_i[0];
    assign thresh_wr_s = wr_s & (offset_s == OFF_THRESH);

    // Sampling is qualified by the FSM having left IDLE; x/y are taken as given.
    assign samp_s     = sample_en & (state_q != ST_IDLE);
    assign mism_s     = samp_s & ((x != 4'd0) | y);
    assign cap_word_s = {sample_cnt_q[15:0], 1'b0, y, x, carry2, carry1, alu_out2, alu_out1};

    // Zero-extend the CNT_W-wide registers and merge byte lanes for THRESH writes.
    always_comb begin
        thresh_ext_s = 32'd0;
        thresh_ext_s[CNT_W-1:0] = thresh_q;
        mism_ext_s = 32'd0;
        mism_ext_s[CNT_W-1:0] = mism_cnt_q;
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                thresh_wdat_s[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end else begin
                thresh_wdat_s[8*b +: 8] = thresh_ext_s[8*b +: 8];
            end
        end
    end

    // Bits of the merged THRESH word above CNT_W have no storage behind them.
    assign unused_s = ^thresh_wdat_s;

    // FSM state and registered interrupt.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

    // FSM next state: en=0 write dominates; clr keeps a RUN from faulting that edge.
    always_comb begin
        state_d = state_q;
        if (en_off_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_q) state_d = ST_RUN;
                    else      state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (!clr_s && (thresh_q != {CNT_W{1'b0}}) && (mism_cnt_q >= thresh_q)) state_d = ST_FAULT;
                    else                                                                 state_d = ST_RUN;
                end
                ST_FAULT: begin
                    if (clr_s) state_d = ST_RUN;
                    else       state_d = ST_FAULT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: status bits from the current state, irq from the next state.
    always_comb begin
        irq_d = (state_d == ST_FAULT);
        case (state_q)
            ST_RUN:   begin running_s = 1'b1; fault_s = 1'b0; end
            ST_FAULT: begin running_s = 1'b0; fault_s = 1'b1; end
            default:  begin running_s = 1'b0; fault_s = 1'b0; end
        endcase
    end

    // Register read multiplexer; counters are read before this edge's update.
    always_comb begin
        case (offset_s)
            OFF_CTRL:   rdata_s = {31'd0, en_q};
            OFF_STATUS: rdata_s = {29'd0, cap_q, fault_s, running_s};
            OFF_SAMPLE: rdata_s = sample_cnt_q;
            OFF_MISM:   rdata_s = mism_ext_s;
            OFF_CAPT:   rdata_s = capture_q;
            OFF_THRESH: rdata_s = thresh_ext_s;
            default:    rdata_s = 32'd0;
        endcase
    end

    // Wishbone ack pulse and read data, registered together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            ack_q <= req_s;
            if (req_s && !wbs_we_i) dat_q <= rdata_s;
            else                    dat_q <= 32'd0;
        end
    end

    // Writable control registers: CTRL.en and THRESH.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q     <= 1'b0;
            thresh_q <= CNT_W'(DEF_THRESH);
        end else begin
            if (ctrl_wr_s)   en_q     <= wbs_dat_i[0];
            if (thresh_wr_s) thresh_q <= thresh_wdat_s[CNT_W-1:0];
        end
    end

    // Saturating counters and first-mismatch capture; clr beats a same-edge sample.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sample_cnt_q <= 32'd0;
            mism_cnt_q   <= {CNT_W{1'b0}};
            capture_q    <= 32'd0;
            cap_q        <= 1'b0;
        end else if (clr_s) begin
            sample_cnt_q <= 32'd0;
            mism_cnt_q   <= {CNT_W{1'b0}};
            capture_q    <= 32'd0;
            cap_q        <= 1'b0;
        end else begin
            if (samp_s && (sample_cnt_q != 32'hFFFF_FFFF)) sample_cnt_q <= sample_cnt_q + 32'd1;
            if (mism_s && (mism_cnt_q != {CNT_W{1'b1}}))  mism_cnt_q   <= mism_cnt_q + CNT_W'(1);
            if (mism_s && !cap_q) begin
                capture_q <= cap_word_s;
                cap_q     <= 1'b1;
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

endmodule
